rr_mux4_arbiter: RTL and testbench

- Four-requester round-robin arbiter with a registered output stage. It shares one WIDTH-bit resource port, such as the register-file write port or a memory port, between four sources.
- It generates the 2-bit select for the 4-way routing mux, grants one requester per accepted transfer and holds the result in an output register until the consumer accepts it.
- Optional per-requester lock gives a requester short bursts, capped at MAX_BURST beats, without starving the others.

---
 rtl/rr_mux4_arbiter.sv | 125 ++++++++++++
 tb/tb_rr_mux4_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rr_mux4_arbiter.sv
// Four-requester round-robin arbiter feeding one registered WIDTH-bit output port.
// Optional per-requester lock keeps priority for bursts of up to MAX_BURST beats.
module rr_mux4_arbiter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [3:0]       lock,
    input  logic [WIDTH-1:0] data_in0,
    input  logic [WIDTH-1:0] data_in1,
    input  logic [WIDTH-1:0] data_in2,
    input  logic [WIDTH-1:0] data_in3,
    output logic [3:0]       grant,
    output logic [1:0]       sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic             state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       bcnt_q, bcnt_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic             found;
    logic [1:0]       winner;
    logic [1:0]       idx;
    logic             accept;
    logic [3:0]       cnt_next;
    logic             keep;
    logic [WIDTH-1:0] win_data;

    // Scan from the priority pointer with mod-4 wrap; the first asserted request wins.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        idx    = ptr_q;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        win_data = data_in0;
        case (winner)
            2'd0:    win_data = data_in0;
            2'd1:    win_data = data_in1;
            2'd2:    win_data = data_in2;
            default: win_data = data_in3;
        endcase
    end

    assign accept = found && (state_q == ST_EMPTY || out_ready);

    always_comb begin
        grant = '0;
        if (accept && !reset) begin
            grant[winner] = 1'b1;
        end
    end

    // bcnt never exceeds MAX_BURST-1, so the incremented count fits in 4 bits.
    assign cnt_next = (winner == owner_q) ? bcnt_q + 4'd1 : 4'd1;
    assign keep     = lock[winner] && (cnt_next < 4'(MAX_BURST));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        sel_d   = sel_q;
        bcnt_d  = bcnt_q;
        data_d  = data_q;
        if (accept) begin
            state_d = ST_FULL;
            data_d  = win_data;
            sel_d   = winner;
            owner_d = winner;
            if (keep) begin
                ptr_d  = winner;
                bcnt_d = cnt_next;
            end else begin
                ptr_d  = winner + 2'd1;
                bcnt_d = '0;
            end
        end else if (state_q == ST_FULL && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            owner_q <= '0;
            sel_q   <= '0;
            bcnt_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            sel_q   <= sel_d;
            bcnt_q  <= bcnt_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign sel       = sel_q;
    assign busy      = out_valid || (|req);

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed-vector bench for rr_mux4_arbiter with hand-computed expectations.
module tb_rr_mux4_arbiter;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       req;
    logic [3:0]       lock;
    logic [WIDTH-1:0] data_in0, data_in1, data_in2, data_in3;
    logic [3:0]       grant;
    logic [1:0]       sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             busy;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [WIDTH-1:0] dval [4];

    rr_mux4_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .lock      (lock),
        .data_in0  (data_in0),
        .data_in1  (data_in1),
        .data_in2  (data_in2),
        .data_in3  (data_in3),
        .grant     (grant),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        dval[0] = 32'h1111_0000;
        dval[1] = 32'h2222_0001;
        dval[2] = 32'hA5A5_0002;
        dval[3] = 32'h4444_0003;
        data_in0 = dval[0];
        data_in1 = dval[1];
        data_in2 = dval[2];
        data_in3 = dval[3];

        // Reset state, with requests present to show grant is held low.
        reset     = 1'b1;
        req       = 4'b1111;
        lock      = 4'b0000;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  out_data,       32'd0);
        check("rst_sel",   32'(sel),       32'd0);
        check("rst_grant", 32'(grant),     32'd0);
        check("rst_busy",  32'(busy),      32'd1);
        req   = 4'b0000;
        reset = 1'b0;
        #1;
        check("idle_busy", 32'(busy), 32'd0);

        // Single requester, continuous, then drain.
        tick();
        req = 4'b0100;
        #1;
        check("single_grant0", 32'(grant), 32'b0100);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("single_valid", 32'(out_valid), 32'd1);
            check("single_data",  out_data,       32'hA5A5_0002);
            check("single_sel",   32'(sel),       32'd2);
            check("single_grant", 32'(grant),     32'b0100);
        end
        req = 4'b0000;
        #1;
        check("drain_grant", 32'(grant), 32'd0);
        check("drain_busy_full", 32'(busy), 32'd1);
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_busy",  32'(busy),      32'd0);
        check("drain_data_hold", out_data,   32'hA5A5_0002);
        check("drain_sel_hold",  32'(sel),   32'd2);

        // Pointer is now 3; restart from requester 0 with a mid-cycle reset pulse.
        #2 reset = 1'b1;
        #1 reset = 1'b0;

        // Round robin with all requesting.
        req = 4'b1111;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("rr_grant", 32'(grant), 32'(4'b0001 << (i % 4)));
            tick();
            check("rr_sel",  32'(sel), 32'(i % 4));
            check("rr_data", out_data, dval[i % 4]);
        end

        // Backpressure: last winner was 0, pointer at 1.
        req       = 4'b0011;
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_grant", 32'(grant),     32'd0);
            tick();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_sel",   32'(sel),       32'd0);
            check("bp_data",  out_data,       dval[0]);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_grant", 32'(grant), 32'b0010);
        tick();
        check("bp_release_sel",  32'(sel), 32'd1);
        check("bp_release_data", out_data, dval[1]);

        // Burst lock: requester 0 takes four beats, then 1, then 0 again.
        lock = 4'b0001;
        #1;
        for (int i = 0; i < 6; i++) begin
            automatic logic [1:0] w = (i == 4) ? 2'd1 : 2'd0;
            check("burst_grant", 32'(grant), 32'(4'b0001 << w));
            tick();
            check("burst_sel", 32'(sel), 32'(w));
        end

        // Two unlocked beats leave pointer at 2 with the output full.
        lock = 4'b0000;
        tick();
        tick();
        check("pre_rst_sel",   32'(sel),       32'd1);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        req = 4'b1111;
        #1;
        check("pre_rst_grant", 32'(grant), 32'b0100);
        #1 reset = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data",  out_data,       32'd0);
        check("arst_sel",   32'(sel),       32'd0);
        check("arst_grant", 32'(grant),     32'd0);
        #1 reset = 1'b0;
        #1;
        check("post_rst_grant", 32'(grant), 32'b0001);
        tick();
        check("post_rst_sel",  32'(sel), 32'd0);
        check("post_rst_data", out_data, dval[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
